// File: rtl/gumnut_timer_port_if.sv
// Gumnut I/O port bus: one core-side master, responders hang off the slave modport.
// Read data from idle responders is 0 so several can be OR-combined upstream.
interface gumnut_timer_port_if;
  logic       port_cyc_i;
  logic       port_stb_i;
  logic       port_we_i;
  logic [7:0] port_adr_i;
  logic [7:0] port_dat_i;
  logic       port_ack_o;
  logic [7:0] port_dat_o;

  modport master (
    output port_cyc_i,
    output port_stb_i,
    output port_we_i,
    output port_adr_i,
    output port_dat_i,
    input  port_ack_o,
    input  port_dat_o
  );

  modport slave (
    input  port_cyc_i,
    input  port_stb_i,
    input  port_we_i,
    input  port_adr_i,
    input  port_dat_i,
    output port_ack_o,
    output port_dat_o
  );
endinterface

// File: rtl/gumnut_timer_port.sv
// Programmable interval timer on the Gumnut port bus: 4-register window,
// prescaled 8-bit reloadable down-counter, sticky interrupt request.
module gumnut_timer_port #(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         PRESCALE   = 4,
  parameter int         PRESCALE_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  gumnut_timer_port_if.slave  bus,
  output logic                int_req,
  input  logic                int_ack
);

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_RELOAD = 2'd2;
  localparam logic [1:0] OFS_COUNT  = 2'd3;

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);

  logic                  en, auto_rl, ie, expd;
  logic [7:0]            reload, count;
  logic [PRESCALE_W-1:0] presc;

  logic                  en_nxt, auto_nxt, ie_nxt, exp_nxt, int_req_nxt;
  logic [7:0]            reload_nxt, count_nxt;
  logic [PRESCALE_W-1:0] presc_nxt;
  logic [7:0]            rd_val;

  logic sel, xfer, wr, rd;
  logic wr_ctrl, wr_status, wr_reload, wr_count;
  logic tick, expire, en_rise;

  // Ack toggles while the strobe is held, so a held strobe gets one transfer per two cycles.
  assign sel  = bus.port_cyc_i & bus.port_stb_i & (bus.port_adr_i[7:2] == BASE_ADDR[7:2]);
  assign xfer = sel & ~bus.port_ack_o;
  assign wr   = xfer & bus.port_we_i;
  assign rd   = xfer & ~bus.port_we_i;

  assign wr_ctrl   = wr & (bus.port_adr_i[1:0] == OFS_CTRL);
  assign wr_status = wr & (bus.port_adr_i[1:0] == OFS_STATUS);
  assign wr_reload = wr & (bus.port_adr_i[1:0] == OFS_RELOAD);
  assign wr_count  = wr & (bus.port_adr_i[1:0] == OFS_COUNT);

  assign tick    = en & (presc == PRESC_LAST);
  assign expire  = tick & (count == 8'd0);
  assign en_rise = wr_ctrl & bus.port_dat_i[0] & ~en;

  always_comb begin
    en_nxt   = en;
    auto_nxt = auto_rl;
    ie_nxt   = ie;
    if (wr_ctrl) begin
      en_nxt   = bus.port_dat_i[0];
      auto_nxt = bus.port_dat_i[1];
      ie_nxt   = bus.port_dat_i[2];
    end else if (expire && !auto_rl) begin
      en_nxt = 1'b0;
    end

    reload_nxt = wr_reload ? bus.port_dat_i : reload;

    // Any bus write to COUNT or CTRL discards the tick's decrement/reload.
    count_nxt = count;
    if (wr_count) begin
      count_nxt = bus.port_dat_i;
    end else if (wr_ctrl) begin
      if (en_rise) count_nxt = reload;
    end else if (tick) begin
      if (count != 8'd0)  count_nxt = count - 8'd1;
      else if (auto_rl)   count_nxt = reload;
    end

    if (!en_nxt || !en || tick) presc_nxt = '0;
    else                        presc_nxt = presc + 1'b1;

    exp_nxt = expd;
    if (expire)                               exp_nxt = 1'b1;
    else if (wr_status && bus.port_dat_i[0])  exp_nxt = 1'b0;

    int_req_nxt = int_req;
    if (expire && ie)                                 int_req_nxt = 1'b1;
    else if (int_ack || (wr_ctrl && !bus.port_dat_i[2])) int_req_nxt = 1'b0;
  end

  always_comb begin
    rd_val = 8'h00;
    case (bus.port_adr_i[1:0])
      OFS_CTRL:   rd_val = {5'b0, ie, auto_rl, en};
      OFS_STATUS: rd_val = {6'b0, en, expd};
      OFS_RELOAD: rd_val = reload;
      OFS_COUNT:  rd_val = count;
      default:    rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.port_ack_o <= 1'b0;
      bus.port_dat_o <= 8'h00;
      int_req        <= 1'b0;
      en             <= 1'b0;
      auto_rl        <= 1'b0;
      ie             <= 1'b0;
      expd           <= 1'b0;
      reload         <= 8'h00;
      count          <= 8'h00;
      presc          <= '0;
    end else begin
      bus.port_ack_o <= xfer;
      bus.port_dat_o <= rd ? rd_val : 8'h00;
      int_req        <= int_req_nxt;
      en             <= en_nxt;
      auto_rl        <= auto_nxt;
      ie             <= ie_nxt;
      expd           <= exp_nxt;
      reload         <= reload_nxt;
      count          <= count_nxt;
      presc          <= presc_nxt;
    end
  end

endmodule

// File: doc/gumnut_timer_port.md
Name: gumnut_timer_port

Overview:
Programmable interval timer that acts as a responder on the Gumnut I/O port bus. It decodes a 4-register window, completes each bus cycle with a registered single-cycle ack, and counts down a reloadable 8-bit counter. On expiry it raises int_req and holds it until the core pulses int_ack. It is instantiated inside gumnut_system alongside the other I/O controllers.

Parameters:
BASE_ADDR, 8'h10, port address of register 0; bits [1:0] must be 0; the block occupies BASE_ADDR..BASE_ADDR+3
PRESCALE, 4, clk_i cycles per timer tick; must be >= 1
PRESCALE_W, 8, prescaler counter width; must satisfy 2**PRESCALE_W >= PRESCALE

Ports:
clk_i  input  1  system clock; all state changes on the rising edge
rst_ni  input  1  synchronous reset, active low
port_cyc_i  input  1  bus cycle valid (from core port_cyc_o)
port_stb_i  input  1  strobe (from core port_stb_o)
port_we_i  input  1  1 = write, 0 = read
port_adr_i  input  8  port address
port_dat_i  input  8  write data from core
port_ack_o  output  1  cycle acknowledge to core
port_dat_o  output  8  read data to core; 0 when not acking, so it can be OR-combined
int_req  output  1  interrupt request to core
int_ack  input  1  interrupt acknowledge pulse from core

Behaviour:
- Reset (rst_ni=0 at an edge): port_ack_o=0, port_dat_o=0, int_req=0, CTRL=0, STATUS.expired=0, RELOAD=0, COUNT=0, prescaler=0. A reset during a bus cycle drops ack at that edge; the core must reissue the cycle.
- Select: sel = port_cyc_i & port_stb_i & (port_adr_i[7:2] == BASE_ADDR[7:2]).
- Handshake: port_ack_o <= sel & ~port_ack_o. Ack is a one-cycle pulse one cycle after sel is first seen. A held strobe yields ack on alternate cycles, one cycle per transfer. The write side effect and read capture both occur at the edge where ack rises. port_dat_o <= register value at that edge, else 0.
- Registers (offset = port_adr_i[1:0]):
  0 CTRL RW: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); bits 7:3 read 0.
  1 STATUS: bit0 EXP (write 1 to clear; write 0 has no effect), bit1 RUN (= EN, read-only); other bits read 0.
  2 RELOAD RW, 8 bits.
  3 COUNT: read returns the live count; a write loads the count directly.
- CTRL write with EN going 0->1: COUNT <= RELOAD and prescaler <= 0 at that edge. Clearing EN freezes COUNT and resets the prescaler to 0. Clearing IE also clears int_req.
- Tick: while EN=1, the prescaler counts 0..PRESCALE-1 and wraps. tick = EN & (prescaler == PRESCALE-1).
- On tick with COUNT != 0: COUNT decrements by 1.
- On tick with COUNT == 0 (expiry):
  - EXP <= 1.
  - int_req <= 1 if IE.
  - If AUTO: COUNT <= RELOAD.
  - If not AUTO: EN <= 0 and COUNT stays 0 (one-shot).
  - RELOAD = 0 with AUTO expires on every tick.
- Interrupt: int_req is sticky and clears only on an int_ack high edge or on IE cleared. It is independent of EXP W1C.
- Simultaneous events:
  - expiry and int_ack in the same cycle: int_req stays 1 (set wins).
  - expiry and EXP W1C: EXP stays 1.
  - COUNT or CTRL bus write and tick: the bus write wins for COUNT/EN, and the tick's decrement or reload is discarded.
  - An expiry that clears EN in the same cycle as a CTRL write: the CTRL write wins.
- Addresses outside the window: no ack, no side effects, port_dat_o = 0.

Test Plan:
1. Reset, then read all 4 registers (BASE 0x10) -> each read acked exactly 1 cycle after strobe, data 0x00 for all; int_req=0.
2. Write RELOAD=3, CTRL=0x07 (EN|AUTO|IE), PRESCALE=4 -> COUNT reads 3,2,1,0 at 4-cycle intervals; EXP=1 and int_req=1 16 cycles after enable; COUNT reloads to 3; timer keeps running.
3. Pulse int_ack for 1 cycle after int_req rises -> int_req=0 next edge; EXP remains 1 until STATUS is written with 0x01, then reads 0x02.
4. One-shot: RELOAD=2, CTRL=0x01 -> after 12 cycles EXP=1, CTRL reads 0x00, COUNT stays 0, int_req stays 0 (IE=0).
5. Hold cyc/stb for a COUNT read at address 0x20 (outside the window) -> port_ack_o never asserts and port_dat_o=0. Hold a strobe at 0x13 for 4 cycles -> ack pattern 0,1,0,1.
6. Force an expiry coincident with an int_ack pulse, and separately with an EXP W1C write -> int_req=1 and EXP=1 afterward. Drive rst_ni=0 mid-ack -> ack=0 and all registers 0 at the next edge.
